// File: rtl/traffic_light_ctrl_timed.sv
// Highway/farm-lane signal controller with internal tick prescaler, per-phase
// counters, min/max green times, optional all-red clearance and request latching.
module traffic_light_ctrl_timed #(
  parameter int TICK_DIV       = 1,
  parameter int CNT_W          = 8,
  parameter int HW_MIN_GREEN   = 10,
  parameter int LANE_MIN_GREEN = 2,
  parameter int LANE_MAX_GREEN = 6,
  parameter int YELLOW_TIME    = 3,
  parameter int ALL_RED_TIME   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  output logic [1:0] highway,
  output logic [1:0] lane,
  output logic [2:0] state,
  output logic       req_pending
);

  typedef enum logic [2:0] {
    S_HG  = 3'd0,
    S_HY  = 3'd1,
    S_AR1 = 3'd2,
    S_LG  = 3'd3,
    S_LY  = 3'd4,
    S_AR2 = 3'd5
  } state_e;

  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_GRN = 2'b10;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W:0] HW_MIN_E   = (CNT_W+1)'(HW_MIN_GREEN);
  localparam logic [CNT_W:0] LN_MIN_E   = (CNT_W+1)'(LANE_MIN_GREEN);
  localparam logic [CNT_W:0] LN_MAX_E   = (CNT_W+1)'(LANE_MAX_GREEN);
  localparam logic [CNT_W:0] YEL_E      = (CNT_W+1)'(YELLOW_TIME);
  localparam logic [CNT_W:0] AR_E       = (CNT_W+1)'(ALL_RED_TIME);

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic [1:0]       highway_q, lane_q;
  logic             tick_s;
  logic [CNT_W:0]   elapsed_s;

  function automatic logic [1:0] hw_light(input state_e s);
    case (s)
      S_HG:    hw_light = L_GRN;
      S_HY:    hw_light = L_YEL;
      default: hw_light = L_RED;
    endcase
  endfunction

  function automatic logic [1:0] lane_light(input state_e s);
    case (s)
      S_LG:    lane_light = L_GRN;
      S_LY:    lane_light = L_YEL;
      default: lane_light = L_RED;
    endcase
  endfunction

  // Next-state, prescaler/phase-counter and request-latch computation
  always_comb begin
    tick_s    = (presc_q == PRESC_LAST);
    // elapsed counts the tick completing in this cycle, so exits land on N*TICK_DIV
    elapsed_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, tick_s};
    state_d   = state_q;
    case (state_q)
      S_HG: begin
        if (elapsed_s >= HW_MIN_E && (req_q || sensor)) state_d = S_HY;
        else                                             state_d = S_HG;
      end
      S_HY: begin
        if (elapsed_s == YEL_E) state_d = (ALL_RED_TIME == 0) ? S_LG : S_AR1;
        else                    state_d = S_HY;
      end
      S_AR1: begin
        if (elapsed_s == AR_E) state_d = S_LG;
        else                   state_d = S_AR1;
      end
      S_LG: begin
        if (elapsed_s == LN_MAX_E || (elapsed_s >= LN_MIN_E && !sensor)) state_d = S_LY;
        else                                                              state_d = S_LG;
      end
      S_LY: begin
        if (elapsed_s == YEL_E) state_d = (ALL_RED_TIME == 0) ? S_HG : S_AR2;
        else                    state_d = S_LY;
      end
      S_AR2: begin
        if (elapsed_s == AR_E) state_d = S_HG;
        else                   state_d = S_AR2;
      end
      default: state_d = S_HG;
    endcase

    if (state_d != state_q) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (tick_s) begin
      presc_d = '0;
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      presc_d = presc_q + PW'(1);
      cnt_d   = cnt_q;
    end

    if (state_d == S_LG && state_q != S_LG) req_d = 1'b0;
    else if (state_q == S_HG && sensor)     req_d = 1'b1;
    else                                    req_d = req_q;
  end

  // State, counters and light outputs register; lights decoded from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HG;
      presc_q   <= '0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      highway_q <= L_GRN;
      lane_q    <= L_RED;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      highway_q <= hw_light(state_d);
      lane_q    <= lane_light(state_d);
    end
  end

  assign highway     = highway_q;
  assign lane        = lane_q;
  assign state       = state_q;
  assign req_pending = req_q;

endmodule

// File: tb/tb_traffic_light_ctrl_timed.sv
// Scoreboard bench: two controller configurations driven by shared directed and
// random sensor/reset stimulus, compared against a tick-arithmetic reference model.
module tb_traffic_light_ctrl_timed;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       sensor = 1'b0;
  logic [1:0] hw_a, ln_a, hw_b, ln_b;
  logic [2:0] st_a, st_b;
  logic       rq_a, rq_b;

  traffic_light_ctrl_timed dut_a (
    .clk(clk), .reset(reset), .sensor(sensor),
    .highway(hw_a), .lane(ln_a), .state(st_a), .req_pending(rq_a)
  );

  traffic_light_ctrl_timed #(.TICK_DIV(4), .ALL_RED_TIME(0)) dut_b (
    .clk(clk), .reset(reset), .sensor(sensor),
    .highway(hw_b), .lane(ln_b), .state(st_b), .req_pending(rq_b)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] hw;
    logic [1:0] ln;
    logic       rq;
  } obs_t;

  typedef struct {
    int ep;
    int len;
  } run_t;

  obs_t qa[$];
  obs_t qb[$];
  run_t runs_a[$];
  run_t runs_b[$];
  int   epoch = 0;
  int   checks = 0;
  int   errors = 0;

  int ma_st = 0, ma_c = 0, mb_st = 0, mb_c = 0;
  bit ma_rq = 1'b0, mb_rq = 1'b0;

  // Reference: phase i cycle k has k/td completed ticks; default timing 10/3/6/2
  task automatic ref_step(input int td, input int ar, input bit s, input bit r,
                          input int st_i, input int c_i, input bit rq_i,
                          output int st_o, output int c_o, output bit rq_o);
    int cyc, el, ns;
    if (r) begin
      st_o = 0; c_o = 0; rq_o = 1'b0;
    end else begin
      cyc = c_i + 1;
      el  = cyc / td;
      ns  = st_i;
      case (st_i)
        0: if (el >= 10 && (rq_i || s)) ns = 1;
        1: if (el == 3) ns = (ar == 0) ? 3 : 2;
        2: if (el == ar) ns = 3;
        3: if (el == 6 || (el >= 2 && !s)) ns = 4;
        4: if (el == 3) ns = (ar == 0) ? 0 : 5;
        5: if (el == ar) ns = 0;
        default: ns = 0;
      endcase
      if (ns == 3 && st_i != 3)   rq_o = 1'b0;
      else if (st_i == 0 && s)    rq_o = 1'b1;
      else                        rq_o = rq_i;
      c_o  = (ns != st_i) ? 0 : cyc;
      st_o = ns;
    end
  endtask

  function automatic obs_t expect_obs(input int st, input bit rq);
    obs_t o;
    o.st = 3'(st);
    o.hw = (st == 0) ? 2'b10 : (st == 1) ? 2'b01 : 2'b00;
    o.ln = (st == 3) ? 2'b10 : (st == 4) ? 2'b01 : 2'b00;
    o.rq = rq;
    return o;
  endfunction

  task automatic step(input bit s, input bit r);
    int ns, nc;
    bit nrq;
    sensor = s;
    reset  = r;
    ref_step(1, 1, s, r, ma_st, ma_c, ma_rq, ns, nc, nrq);
    ma_st = ns; ma_c = nc; ma_rq = nrq;
    ref_step(4, 0, s, r, mb_st, mb_c, mb_rq, ns, nc, nrq);
    mb_st = ns; mb_c = nc; mb_rq = nrq;
    @(posedge clk);
    #1;
    qa.push_back(expect_obs(ma_st, ma_rq));
    qb.push_back(expect_obs(mb_st, mb_rq));
  endtask

  task automatic start_scn(input bit s);
    step(s, 1'b1);
    epoch++;
  endtask

  task automatic push_runs_a(input int n, input int l0, input int l1, input int l2,
                             input int l3, input int l4, input int l5, input int l6);
    int v[7];
    v = '{l0, l1, l2, l3, l4, l5, l6};
    for (int i = 0; i < n; i++) runs_a.push_back('{epoch, v[i]});
  endtask

  task automatic push_runs_b(input int n, input int l0, input int l1, input int l2,
                             input int l3, input int l4);
    int v[5];
    v = '{l0, l1, l2, l3, l4};
    for (int i = 0; i < n; i++) runs_b.push_back('{epoch, v[i]});
  endtask

  int       seen_epoch = 0;
  logic [2:0] prev_a, prev_b;
  int       len_a = 0, len_b = 0;

  // Monitor: per-cycle scoreboard pops, light exclusivity and phase run lengths
  always @(negedge clk) begin
    obs_t e;
    run_t rr;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      checks++;
      if ({st_a, hw_a, ln_a, rq_a} !== e) begin
        errors++;
        $display("FAIL obs_a t=%0t got st=%0d hw=%b ln=%b req=%b want st=%0d hw=%b ln=%b req=%b",
                 $time, st_a, hw_a, ln_a, rq_a, e.st, e.hw, e.ln, e.rq);
      end
      checks++;
      if (hw_a != 2'b00 && ln_a != 2'b00) begin
        errors++;
        $display("FAIL excl_a t=%0t got hw=%b ln=%b want one RED", $time, hw_a, ln_a);
      end
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      checks++;
      if ({st_b, hw_b, ln_b, rq_b} !== e) begin
        errors++;
        $display("FAIL obs_b t=%0t got st=%0d hw=%b ln=%b req=%b want st=%0d hw=%b ln=%b req=%b",
                 $time, st_b, hw_b, ln_b, rq_b, e.st, e.hw, e.ln, e.rq);
      end
      checks++;
      if (hw_b != 2'b00 && ln_b != 2'b00) begin
        errors++;
        $display("FAIL excl_b t=%0t got hw=%b ln=%b want one RED", $time, hw_b, ln_b);
      end
    end
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      while (runs_a.size() > 0 && runs_a[0].ep < epoch) begin
        rr = runs_a.pop_front();
        checks++; errors++;
        $display("FAIL run_a_missing got no phase change want run of %0d cycles", rr.len);
      end
      while (runs_b.size() > 0 && runs_b[0].ep < epoch) begin
        rr = runs_b.pop_front();
        checks++; errors++;
        $display("FAIL run_b_missing got no phase change want run of %0d cycles", rr.len);
      end
      prev_a = st_a; len_a = 1;
      prev_b = st_b; len_b = 1;
    end else begin
      if (st_a === prev_a) len_a++;
      else begin
        if (runs_a.size() > 0) begin
          rr = runs_a.pop_front();
          checks++;
          if (len_a != rr.len) begin
            errors++;
            $display("FAIL run_a st=%0d got %0d cycles want %0d", prev_a, len_a, rr.len);
          end
        end
        prev_a = st_a; len_a = 1;
      end
      if (st_b === prev_b) len_b++;
      else begin
        if (runs_b.size() > 0) begin
          rr = runs_b.pop_front();
          checks++;
          if (len_b != rr.len) begin
            errors++;
            $display("FAIL run_b st=%0d got %0d cycles want %0d", prev_b, len_b, rr.len);
          end
        end
        prev_b = st_b; len_b = 1;
      end
    end
  end

  initial begin
    int dens;
    // Sensor held from reset release: full cycle at max lane green
    start_scn(1'b1);
    push_runs_a(7, 10, 3, 1, 6, 3, 1, 10);
    push_runs_b(1, 40, 0, 0, 0, 0);
    repeat (60) step(1'b1, 1'b0);

    // One-cycle pulse at HG cycle 3, lane green ends at minimum
    start_scn(1'b0);
    push_runs_a(6, 10, 3, 1, 2, 3, 1, 0);
    push_runs_b(4, 40, 12, 8, 12, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (80) step(1'b0, 1'b0);

    // Sensor only during LY is not latched; HG then holds
    start_scn(1'b0);
    push_runs_a(6, 10, 3, 1, 2, 3, 1, 0);
    push_runs_b(4, 40, 12, 8, 12, 0);
    step(1'b1, 1'b0);
    while (ma_st != 4) step(1'b0, 1'b0);
    while (ma_st == 4) step(1'b1, 1'b0);
    repeat (70) step(1'b0, 1'b0);

    // Sensor drops at LG cycle 4
    start_scn(1'b1);
    push_runs_a(6, 10, 3, 1, 4, 3, 1, 0);
    push_runs_b(4, 40, 12, 8, 12, 0);
    while (ma_st != 3) step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    repeat (70) step(1'b0, 1'b0);

    // Reset during LG cycle 2 restarts a full minimum highway green
    start_scn(1'b1);
    while (ma_st != 3) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    start_scn(1'b1);
    push_runs_a(1, 10, 0, 0, 0, 0, 0, 0);
    repeat (15) step(1'b1, 1'b0);

    // Long held request: prescaled config without all-red phases
    start_scn(1'b1);
    push_runs_a(7, 10, 3, 1, 6, 3, 1, 10);
    push_runs_b(5, 40, 12, 24, 12, 40);
    repeat (140) step(1'b1, 1'b0);

    // Random sensor density with occasional reset
    start_scn(1'b0);
    dens = 20;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) dens = $urandom_range(0, 100);
      step($urandom_range(0, 99) < dens, $urandom_range(0, 299) == 0);
    end

    epoch++;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
